// File: rtl/rnn_frame_sequencer.sv
// rnn_frame_sequencer: assembles N_FEAT feature words into a frame, starts the RNN, then streams vad + N_GAIN gains out.
// Define RNN_TIMEOUT_EN to add a watchdog that aborts the result wait after TIMEOUT_CYC cycles.
module rnn_frame_sequencer #(
  parameter int FIXED  = 32,
  parameter int N_FEAT = 42,
  parameter int N_GAIN = 22
`ifdef RNN_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [FIXED-1:0]        in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [N_FEAT*FIXED-1:0] rnn_feature,
  output logic                    rnn_start,
  input  logic                    rnn_valid,
  input  logic [FIXED-1:0]        rnn_vad,
  input  logic [N_GAIN*FIXED-1:0] rnn_gains,
  output logic [FIXED-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int CNT_MAX = (N_FEAT > N_GAIN + 1) ? N_FEAT : N_GAIN + 1;
  localparam int CW = $clog2(CNT_MAX);
  localparam int FW = $clog2(N_FEAT);
  localparam int GW = $clog2(N_GAIN);
  localparam logic [CW-1:0] LAST_FEAT = CW'(N_FEAT - 1);
  localparam logic [CW-1:0] LAST_GAIN = CW'(N_GAIN);

  typedef enum logic [1:0] {ST_COLLECT, ST_START, ST_WAIT, ST_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic              armed_q;
  logic              feat_we, capture, drain_adv;
  logic [FIXED-1:0]  feat_q [N_FEAT];
  logic [FIXED-1:0]  gain_q [N_GAIN];
  logic [FIXED-1:0]  vad_q;
  logic [GW-1:0]     gidx;

`ifdef RNN_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);
  logic [WDW-1:0] wd_q;
  logic           timeout_hit;
  logic           timeout_err_q;
`endif

  // in_ready stays low until the first clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    rnn_start = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    feat_we   = 1'b0;
    capture   = 1'b0;
    drain_adv = 1'b0;
`ifdef RNN_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      ST_COLLECT: begin
        in_ready = armed_q;
        if (in_valid && armed_q) begin
          feat_we = 1'b1;
          if (cnt_q == LAST_FEAT) state_d = ST_START;
        end
      end
      ST_START: begin
        rnn_start = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (rnn_valid) begin
          capture = 1'b1;
          state_d = ST_DRAIN;
        end
`ifdef RNN_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          timeout_hit = 1'b1;
          state_d     = ST_COLLECT;
        end
`endif
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_last  = (cnt_q == LAST_GAIN);
        if (out_ready) begin
          drain_adv = 1'b1;
          if (cnt_q == LAST_GAIN) state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // one counter serves both the feature index and the result-word index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (feat_we) begin
      cnt_q <= (cnt_q == LAST_FEAT) ? '0 : cnt_q + 1'b1;
    end else if (capture) begin
      cnt_q <= '0;
    end else if (drain_adv) begin
      cnt_q <= (cnt_q == LAST_GAIN) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_FEAT; k++) feat_q[k] <= '0;
    end else if (feat_we) begin
      feat_q[FW'(cnt_q)] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vad_q <= '0;
      for (int k = 0; k < N_GAIN; k++) gain_q[k] <= '0;
    end else if (capture) begin
      vad_q <= rnn_vad;
      for (int k = 0; k < N_GAIN; k++) gain_q[k] <= rnn_gains[k*FIXED +: FIXED];
    end
  end

  for (genvar g = 0; g < N_FEAT; g++) begin : g_pack
    assign rnn_feature[g*FIXED +: FIXED] = feat_q[g];
  end

  assign gidx     = GW'(cnt_q - 1'b1);
  assign out_data = !out_valid ? '0 : (cnt_q == '0) ? vad_q : gain_q[gidx];
  assign busy     = (state_q != ST_COLLECT);

`ifdef RNN_TIMEOUT_EN
  // watchdog restarts every time the start pulse is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == ST_START)     wd_q <= '0;
      else if (state_q == ST_WAIT) wd_q <= wd_q + 1'b1;
      if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_rnn_frame_sequencer.sv
// tb_rnn_frame_sequencer: directed bench playing feature source, RNN and result sink around rnn_frame_sequencer.
// With RNN_TIMEOUT_EN the DUT is built with a 16-cycle watchdog.
module tb_rnn_frame_sequencer;

  localparam int FIXED  = 32;
  localparam int N_FEAT = 42;
  localparam int N_GAIN = 22;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [FIXED-1:0]        in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [N_FEAT*FIXED-1:0] rnn_feature;
  logic                    rnn_start;
  logic                    rnn_valid;
  logic [FIXED-1:0]        rnn_vad;
  logic [N_GAIN*FIXED-1:0] rnn_gains;
  logic [FIXED-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic                    busy;
  logic                    timeout_err;

  int vec_count  = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rnn_frame_sequencer #(
    .FIXED(FIXED), .N_FEAT(N_FEAT), .N_GAIN(N_GAIN)
`ifdef RNN_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rnn_feature(rnn_feature), .rnn_start(rnn_start),
    .rnn_valid(rnn_valid), .rnn_vad(rnn_vad), .rnn_gains(rnn_gains),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // drive one feature word and hold it until accepted
  task automatic applyStimulus(input logic [31:0] word);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = word;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) checkOutput("in_ready wait", 32'(in_ready), 32'd1);
    @(posedge clk);
  endtask

  // returns at the negedge of the expected start cycle
  task automatic feedFrame(input logic [31:0] base);
    for (int k = 0; k < N_FEAT; k++) begin
      applyStimulus(base + 32'(k));
      #1;
      if (k < N_FEAT - 1) checkOutput("no early start", 32'(rnn_start), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("rnn_start pulse", 32'(rnn_start), 32'd1);
    checkOutput("in_ready in start", 32'(in_ready), 32'd0);
    checkOutput("busy in start", 32'(busy), 32'd1);
  endtask

  task automatic drainResult(input logic [31:0] vad, input logic [31:0] gbase, input bit toggle);
    int idx = 0;
    int cyc = 0;
    logic [31:0] exp_word;
    while (idx <= N_GAIN && cyc < 200) begin
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      exp_word  = (idx == 0) ? vad : gbase + 32'(idx - 1);
      checkOutput("out_valid", 32'(out_valid), 32'd1);
      checkOutput("out_data", out_data, exp_word);
      checkOutput("out_last", 32'(out_last), 32'(idx == N_GAIN));
      @(posedge clk);
      if (out_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (idx <= N_GAIN) checkOutput("drain budget", 32'(idx), 32'(N_GAIN + 1));
    checkOutput("out_valid after last", 32'(out_valid), 32'd0);
    checkOutput("busy after last", 32'(busy), 32'd0);
    checkOutput("in_ready after last", 32'(in_ready), 32'd1);
  endtask

  // called at the start-cycle negedge; answers 5 cycles after start
  task automatic runResult(input logic [31:0] vad, input logic [31:0] gbase, input logic [31:0] fbase,
                           input bit toggle);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        rnn_valid = 1'b0;
        checkOutput("start one cycle", 32'(rnn_start), 32'd0);
        in_valid = 1'b1;
        in_data  = 32'hBADBAD00;
      end
      checkOutput("no out in wait", 32'(out_valid), 32'd0);
      checkOutput("busy in wait", 32'(busy), 32'd1);
      if (c == 4) begin
        checkOutput("held word ignored", rnn_feature[0 +: FIXED], fbase);
        in_valid = 1'b0;
      end
    end
    rnn_valid = 1'b1;
    rnn_vad   = vad;
    for (int k = 0; k < N_GAIN; k++) rnn_gains[k*FIXED +: FIXED] = gbase + 32'(k);
    @(negedge clk);
    rnn_valid = 1'b0;
    rnn_vad   = 32'hDEAD0001;
    for (int k = 0; k < N_GAIN; k++) rnn_gains[k*FIXED +: FIXED] = 32'hDEAD1000 + 32'(k);
    drainResult(vad, gbase, toggle);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    rnn_valid = 1'b0;
    rnn_vad   = '0;
    rnn_gains = '0;
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset rnn_start", 32'(rnn_start), 32'd0);
    checkOutput("reset out_data", out_data, 32'd0);
    checkOutput("reset timeout_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;

    $display("[TB] mid-frame reset after 10 words");
    for (int k = 0; k < 10; k++) applyStimulus(32'hA000 + 32'(k));
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < 10; k++) checkOutput("reset feature", rnn_feature[k*FIXED +: FIXED], 32'd0);
    checkOutput("reset in_ready mid", 32'(in_ready), 32'd0);
    checkOutput("reset busy mid", 32'(busy), 32'd0);
    checkOutput("reset out_last", 32'(out_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] frame 1: counting features, plain drain");
    feedFrame(32'h0);
    for (int k = 0; k < N_FEAT; k++) checkOutput("feature word", rnn_feature[k*FIXED +: FIXED], 32'(k));
    runResult(32'h00010000, 32'h100, 32'h0, 1'b0);

    $display("[TB] frame 2: spurious rnn_valid, backpressure");
    rnn_valid = 1'b1;
    rnn_vad   = 32'hDEAD0002;
    @(negedge clk);
    checkOutput("spurious collect out_valid", 32'(out_valid), 32'd0);
    checkOutput("spurious collect busy", 32'(busy), 32'd0);
    feedFrame(32'h1000);
    checkOutput("frame2 first", rnn_feature[0 +: FIXED], 32'h1000);
    checkOutput("frame2 last", rnn_feature[(N_FEAT-1)*FIXED +: FIXED], 32'h1029);
    runResult(32'h00020000, 32'h200, 32'h1000, 1'b1);

`ifdef RNN_TIMEOUT_EN
    $display("[TB] frame 3: watchdog");
    feedFrame(32'h3000);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      checkOutput("wd busy", 32'(busy), 32'd1);
      checkOutput("wd no err yet", 32'(timeout_err), 32'd0);
      checkOutput("wd no out", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    checkOutput("wd err", 32'(timeout_err), 32'd1);
    checkOutput("wd back to collect", 32'(busy), 32'd0);
    checkOutput("wd in_ready", 32'(in_ready), 32'd1);
    checkOutput("wd no out after", 32'(out_valid), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("wd sticky", 32'(timeout_err), 32'd1);
`else
    checkOutput("timeout_err tied", 32'(timeout_err), 32'd0);
`endif

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
